exec_controller: RTL
====================

# exec_controller

Execution controller for the AES ASIP: turns the board's raw `pwr`, `dbg` and `stp` switch/button inputs into a registered, single-clock-domain `cpu_en` clock-enable for the processor and data memory. It provides three behaviours:
- power-up start;
- free-running execution;
- debug halt with button-driven single/multi-cycle stepping.

It sits in the encryptor top between the board I/O and the processor/memory enables, so the design never gates the clock.

## Interface
Parameters:
- `N`, 32, width of `cycle_count`
- `DB_CYCLES`, 50000, number of consecutive stable samples required to accept a `stp` level change (used only when debounce is compiled in)
- `STEP_CYCLES`, 1, number of `cpu_en` cycles issued per accepted step press; legal range 1..255

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; synchronous, active-high
- `pwr`  in  1  raw power switch, asynchronous
- `dbg`  in  1  raw debug-mode switch, asynchronous
- `stp`  in  1  raw step button, asynchronous, active-high
- `cpu_en`  out  1  registered enable to processor and memory
- `halted`  out  1  high in HALT
- `state`  out  2  current FSM state encoding
- `cycle_count`  out  N  number of cycles with `cpu_en`=1 since reset

## Operation
- All three raw inputs pass through 2-FF synchronizers, giving `pwr_s`, `dbg_s` and `stp_s`.
- `pwr_fall` = `pwr_s` falling edge. Start is sticky, as in the existing power-up convention.
- `stp_s` goes through the debouncer (see Configuration), giving `stp_db`. `step_req` = one-cycle pulse on the rising edge of `stp_db`.
- FSM states: OFF=2'd0, RUN=2'd1, HALT=2'd2, STEP=2'd3.
  - OFF: `cpu_en`=0. On `pwr_fall`, go to HALT if `dbg_s`=1, else RUN.
  - RUN: `cpu_en`=1. If `dbg_s`=1, go to HALT.
  - HALT: `cpu_en`=0. If `dbg_s`=0, go to RUN. Else if `step_req`, load `step_cnt`=`STEP_CYCLES` and go to STEP.
  - STEP: `cpu_en`=1 and `step_cnt` decrements each cycle. When `step_cnt` reaches 1:
    - go to HALT if `dbg_s`=1, else go to RUN.
    - `dbg_s` falling during STEP does not abort the step; the remaining count completes first.
- `step_req` pulses while in STEP or RUN are discarded, not queued.
- Simultaneous `dbg_s`=0 and `step_req` in HALT: `dbg_s`=0 wins and the FSM goes to RUN.
- After start, `pwr` toggles have no effect. Only `rst` returns the FSM to OFF.
- `cycle_count` increments on every cycle where `cpu_en`=1 and wraps modulo 2^N.
- `step_cnt` is 8 bits wide.

## Timing
- Reset values:
  - `cpu_en`=0, `halted`=0, `state`=OFF, `cycle_count`=0.
  - `step_cnt`=0, debounce counter=0, all synchronizer flops 0.
- `rst` asserted mid-operation, including mid-STEP: the next edge forces all of the above reset values.
- `cpu_en`, `halted` and `state` are registered and change on the edge on which the FSM transitions.
- Latency from a raw `pwr` falling edge to `cpu_en`=1 in RUN: 4 clk (2 sync + 1 edge register + 1 FSM).
- Latency from a raw `dbg` rise to `cpu_en`=0: 3 clk.
- Step press with debounce: `cpu_en` rises `DB_CYCLES`+4 clk after `stp` becomes stable high, and stays high for exactly `STEP_CYCLES` consecutive cycles.

## Configuration
- Macro `EXEC_CTRL_DEBOUNCE_EN`.
  - Defined: `stp_db` changes only after `stp_s` has held a new level for `DB_CYCLES` consecutive clocks. Any bounce restarts the count from 0.
  - Undefined: `stp_db` = `stp_s`, the debounce counter is not instantiated, and step latency is 4 clk. This is the configuration used in simulation.

## Structure
- Package `exec_ctrl_pkg`:
  - `typedef enum logic [1:0] {OFF, RUN, HALT, STEP} exec_state_t`
  - `localparam STEP_CNT_W = 8`
- Sub-module `input_conditioner`: 2-FF synchronizer, optional debouncer and rising/falling edge pulses for one signal. It is instantiated three times; the `pwr` and `dbg` instances have debounce bypassed.

## Test plan
- Reset, then hold `pwr`=1 and `dbg`=0 for 10 clk, then `pwr`=0 → `cpu_en`=1 exactly 4 clk later; `cycle_count`=20 after 20 more clk.
- From RUN, raise `dbg` → `cpu_en`=0 and `state`=2 3 clk later; `cycle_count` frozen.
- HALT, `STEP_CYCLES`=3, macro undefined, one `stp` pulse of 5 clk → exactly 3 cycles of `cpu_en`=1, then HALT; `cycle_count` advances by 3.
- Macro defined, `DB_CYCLES`=8, `stp` bouncing 1/0 every 3 clk for 30 clk, then steady high → a single step, starting 12 clk after the level settles.
- Drop `dbg` during a 3-cycle STEP → the step completes, then the FSM enters RUN; assert `rst` mid-RUN → `state`=0, `cpu_en`=0, `cycle_count`=0 on the next edge, and a second `pwr` toggle restarts execution.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exec_ctrl_pkg
// Shared types and constants for the AES ASIP execution controller.
//   exec_state_t : FSM state encoding (OFF=0, RUN=1, HALT=2, STEP=3)
//   STEP_CNT_W   : width of the step-burst down-counter
// ---------------------------------------------------------------------------
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } exec_state_t;

  localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Brings one raw asynchronous board input into the clk domain: 2-FF
// synchronizer, optional debouncer, and registered one-cycle rise/fall pulses.
//
// The debouncer is compiled only when EXEC_CTRL_DEBOUNCE_EN is defined, and
// then only in instances with DEBOUNCE=1. Otherwise the conditioned level is
// the synchronizer output.
//
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   raw_i   in  raw asynchronous input
//   level_o out conditioned (synchronized / debounced) level
//   rise_o  out one-cycle pulse, registered, on level_o 0->1
//   fall_o  out one-cycle pulse, registered, on level_o 1->0
// ---------------------------------------------------------------------------
module input_conditioner
  import exec_ctrl_pkg::*;
#(
  parameter bit          DEBOUNCE  = 1'b0,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic cond;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef EXEC_CTRL_DEBOUNCE_EN
  if (DEBOUNCE) begin : g_db
    logic [31:0] db_cnt_q;
    logic [31:0] db_cnt_d;
    logic        db_q;
    logic        db_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement (a bounce) clears it.
    always_comb begin
      db_cnt_d = '0;
      db_d     = db_q;
      if (sync2_q != db_q) begin
        if (db_cnt_q == DB_CYCLES - 32'd1) begin
          db_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt_q <= '0;
        db_q     <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        db_q     <= db_d;
      end
    end

    assign cond = db_q;
  end else begin : g_nodb
    assign cond = sync2_q;
  end
`else
  assign cond = sync2_q;
  logic unused_cfg;
  assign unused_cfg = DEBOUNCE ^ (DB_CYCLES == 0);
`endif

  // prev_q resets to 0, so an input already high at reset release yields a
  // rise pulse but never a spurious fall pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= cond;
      rise_q <= cond & ~prev_q;
      fall_q <= ~cond & prev_q;
    end
  end

  assign level_o = cond;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/exec_controller.sv
// ---------------------------------------------------------------------------
// exec_controller
// Execution controller for the AES ASIP. Converts the raw pwr/dbg/stp board
// inputs into a registered clock-enable (cpu_en) for processor and memory:
// power-up start, free running, and debug halt with button stepping.
//
// Build option: define EXEC_CTRL_DEBOUNCE_EN to debounce the stp button over
// DB_CYCLES clocks; undefined, stp is only synchronized.
//
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   pwr         in  raw power switch; its first falling edge starts execution
//   dbg         in  raw debug-mode switch (1 = halt / step mode)
//   stp         in  raw step button, active-high
//   cpu_en      out registered enable to processor and memory
//   halted      out high while in HALT
//   state       out current FSM state (exec_state_t encoding)
//   cycle_count out number of cpu_en=1 cycles since reset, wraps mod 2^N
// ---------------------------------------------------------------------------
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int          N           = 32,
  parameter int unsigned DB_CYCLES   = 50000,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwr,
  input  logic         dbg,
  input  logic         stp,
  output logic         cpu_en,
  output logic         halted,
  output logic [1:0]   state,
  output logic [N-1:0] cycle_count
);

  logic pwr_fall;
  logic dbg_s;
  logic step_req;
  logic unused_pwr_level;
  logic unused_pwr_rise;
  logic unused_dbg_rise;
  logic unused_dbg_fall;
  logic unused_stp_level;
  logic unused_stp_fall;

  input_conditioner #(.DEBOUNCE(1'b0), .DB_CYCLES(DB_CYCLES)) u_pwr (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (pwr),
    .level_o (unused_pwr_level),
    .rise_o  (unused_pwr_rise),
    .fall_o  (pwr_fall)
  );

  input_conditioner #(.DEBOUNCE(1'b0), .DB_CYCLES(DB_CYCLES)) u_dbg (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (dbg),
    .level_o (dbg_s),
    .rise_o  (unused_dbg_rise),
    .fall_o  (unused_dbg_fall)
  );

  input_conditioner #(.DEBOUNCE(1'b1), .DB_CYCLES(DB_CYCLES)) u_stp (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (stp),
    .level_o (unused_stp_level),
    .rise_o  (step_req),
    .fall_o  (unused_stp_fall)
  );

  exec_state_t           state_q;
  exec_state_t           state_d;
  logic [STEP_CNT_W-1:0] step_cnt_q;
  logic [STEP_CNT_W-1:0] step_cnt_d;
  logic                  cpu_en_q;
  logic                  halted_q;
  logic [N-1:0]          cycle_count_q;

  // step_req is only acted on in HALT; pulses in RUN/STEP fall through and
  // are lost. In HALT a low dbg_s is checked first so leaving debug mode wins
  // over a coincident step press.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    case (state_q)
      OFF: begin
        if (pwr_fall) state_d = dbg_s ? HALT : RUN;
      end
      RUN: begin
        if (dbg_s) state_d = HALT;
      end
      HALT: begin
        if (!dbg_s) begin
          state_d = RUN;
        end else if (step_req) begin
          step_cnt_d = STEP_CNT_W'(STEP_CYCLES);
          state_d    = STEP;
        end
      end
      STEP: begin
        // dbg_s is only consulted on the last burst cycle, so a step is
        // never cut short.
        step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
        if (step_cnt_q == STEP_CNT_W'(1)) state_d = dbg_s ? HALT : RUN;
      end
      default: state_d = OFF;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= OFF;
      step_cnt_q    <= '0;
      cpu_en_q      <= 1'b0;
      halted_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_cnt_q    <= step_cnt_d;
      cpu_en_q      <= (state_d == RUN) || (state_d == STEP);
      halted_q      <= (state_d == HALT);
      cycle_count_q <= cycle_count_q + N'(cpu_en_q);
    end
  end

  assign cpu_en      = cpu_en_q;
  assign halted      = halted_q;
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

endmodule
